// File: rtl/ball_track_pkg.sv
// ball_track_pkg: shared state type, default widths/thresholds and divider width check.
package ball_track_pkg;
  typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, PUBLISH} state_t;
  localparam int X_W_DEF = 11;
  localparam int Y_W_DEF = 10;
  localparam int CNT_W_DEF = 20;
  localparam int DIV_W_DEF = 32;
  localparam logic [7:0] R_MIN_DEF = 8'd180;
  localparam logic [7:0] G_MAX_DEF = 8'd140;
  localparam logic [7:0] B_MAX_DEF = 8'd80;
  localparam int MIN_PIX_DEF = 64;
  function automatic bit div_w_ok(int dw, int xw, int cw);
    return dw >= xw + cw;
  endfunction
endpackage

// File: rtl/ball_centroid_div.sv
// ball_centroid_div: serial restoring divider, one quotient bit per cycle, done DIV_W cycles after start.
module ball_centroid_div #(
  parameter int DIV_W = 32,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(DIV_W + 1);
  logic [CNT_W-1:0] rem_q, rem_in, rem_n;
  logic [DIV_W-1:0] quo_q, quo_in, quo_n;
  logic [CNT_W:0] trial, diff;
  logic [CW-1:0] cnt_q;
  logic busy_q, done_q, ge;
  // The first quotient bit is resolved on the start edge itself.
  always_comb begin
    rem_in = start ? '0 : rem_q;
    quo_in = start ? dividend : quo_q;
    trial = {rem_in, quo_in[DIV_W-1]};
    diff = trial - {1'b0, divisor};
    ge = trial >= {1'b0, divisor};
    rem_n = CNT_W'(ge ? diff : trial);
    quo_n = {quo_in[DIV_W-2:0], ge};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= CW'(DIV_W - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end
  assign quotient = quo_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: rtl/ball_centroid_tracker.sv
// ball_centroid_tracker: per-frame colour-window centroid of video pixels, published after serial division.
module ball_centroid_tracker
  import ball_track_pkg::*;
#(
  parameter int         X_W       = X_W_DEF,
  parameter int         Y_W       = Y_W_DEF,
  parameter int         CNT_W     = CNT_W_DEF,
  parameter int         DIV_W     = DIV_W_DEF,
  parameter logic [7:0] R_MIN     = R_MIN_DEF,
  parameter logic [7:0] G_MAX     = G_MAX_DEF,
  parameter logic [7:0] B_MAX     = B_MAX_DEF,
  parameter int         MIN_PIX   = MIN_PIX_DEF,
  parameter bit         VSYNC_POL = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [23:0]      vid_data,
  input  logic             vid_datavalid,
  input  logic             vid_v_sync,
  input  logic             vid_underflow,
  input  logic             enable,
  input  logic             overrun_clr,
  output logic [X_W-1:0]   ball_x,
  output logic [Y_W-1:0]   ball_y,
  output logic [CNT_W-1:0] ball_pixels,
  output logic             ball_found,
  output logic             result_valid,
  output logic             overrun
);
  if (!div_w_ok(DIV_W, X_W, CNT_W)) begin : g_div_w_chk
    $error("DIV_W must be >= X_W + CNT_W");
  end
  state_t state_q, state_d;
  logic vs_q, dv_q, e, fall, hit, found, accept, go_q, go_d, pub_small, pub_div;
  logic div_busy, div_done, first_q, frame_bad_q, overrun_q, result_valid_q, ball_found_q;
  logic [X_W-1:0] x_q, x_d, x_cur, qx_q, ball_x_q;
  logic [Y_W-1:0] y_q, y_d, ball_y_q;
  logic [DIV_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d, snap_x_q, snap_y_q, div_q;
  logic [CNT_W-1:0] cnt_q, cnt_b, cnt_d, snap_cnt_q, ball_pixels_q;
  always_comb begin
    e = VSYNC_POL ? (vid_v_sync & ~vs_q) : (~vid_v_sync & vs_q);
    fall = dv_q & ~vid_datavalid;
    hit = vid_datavalid & enable & (vid_data[23:16] >= R_MIN) & (vid_data[15:8] <= G_MAX)
        & (vid_data[7:0] <= B_MAX);
    x_cur = e ? '0 : x_q;
    x_d = vid_datavalid ? ((&x_cur) ? x_cur : x_cur + X_W'(1)) : fall ? '0 : x_cur;
    y_d = e ? '0 : fall ? ((&y_q) ? y_q : y_q + Y_W'(1)) : y_q;
    sum_x_d = (e ? '0 : sum_x_q) + (hit ? DIV_W'(x_cur) : '0);
    sum_y_d = (e ? '0 : sum_y_q) + (hit ? DIV_W'(e ? '0 : y_q) : '0);
    cnt_b = e ? '0 : cnt_q;
    cnt_d = (hit & ~&cnt_b) ? cnt_b + CNT_W'(1) : cnt_b;
    found = cnt_q >= CNT_W'(MIN_PIX);
    accept = (state_q == ACCUM) & e & ~first_q & ~frame_bad_q & enable;
  end
  always_comb begin
    state_d = state_q;
    go_d = 1'b0;
    pub_small = 1'b0;
    pub_div = 1'b0;
    unique case (state_q)
      ACCUM: if (accept) begin
        state_d = found ? DIV_X : PUBLISH;
        go_d = found;
        pub_small = ~found;
      end
      DIV_X: if (div_done) begin
        state_d = DIV_Y;
        go_d = 1'b1;
      end
      DIV_Y: if (div_done) begin
        state_d = PUBLISH;
        pub_div = 1'b1;
      end
      default: state_d = ACCUM;
    endcase
  end
  ball_centroid_div #(.DIV_W(DIV_W), .CNT_W(CNT_W)) u_div (
    .clk(clk_clk),
    .rst(reset_reset),
    .start(go_q),
    .dividend(state_q == DIV_X ? snap_x_q : snap_y_q),
    .divisor(snap_cnt_q),
    .quotient(div_q),
    .busy(div_busy),
    .done(div_done)
  );
  // Results register on the edge into PUBLISH so they line up with result_valid.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= ACCUM;
      {vs_q, dv_q, go_q, frame_bad_q, overrun_q, result_valid_q, ball_found_q} <= '0;
      first_q <= 1'b1;
      {x_q, qx_q, ball_x_q, y_q, ball_y_q} <= '0;
      {sum_x_q, sum_y_q, snap_x_q, snap_y_q} <= '0;
      {cnt_q, snap_cnt_q, ball_pixels_q} <= '0;
    end else begin
      state_q <= state_d;
      vs_q <= vid_v_sync;
      dv_q <= vid_datavalid;
      go_q <= go_d;
      x_q <= x_d;
      y_q <= y_d;
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      cnt_q <= cnt_d;
      frame_bad_q <= (e ? 1'b0 : frame_bad_q) | vid_underflow;
      first_q <= first_q & ~e;
      overrun_q <= (e & ((state_q != ACCUM) | div_busy)) ? 1'b1 : overrun_clr ? 1'b0 : overrun_q;
      result_valid_q <= pub_small | pub_div;
      if (accept) begin
        snap_x_q <= sum_x_q;
        snap_y_q <= sum_y_q;
        snap_cnt_q <= cnt_q;
      end
      if (div_done & (state_q == DIV_X)) qx_q <= X_W'(div_q);
      if (pub_small) begin
        ball_pixels_q <= cnt_q;
        ball_found_q <= 1'b0;
      end
      if (pub_div) begin
        ball_pixels_q <= snap_cnt_q;
        ball_found_q <= 1'b1;
        ball_x_q <= qx_q;
        ball_y_q <= Y_W'(div_q);
      end
    end
  end
  assign ball_x = ball_x_q;
  assign ball_y = ball_y_q;
  assign ball_pixels = ball_pixels_q;
  assign ball_found = ball_found_q;
  assign result_valid = result_valid_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_ball_centroid_tracker.sv
// tb_ball_centroid_tracker: directed frames with hand-computed centroids, latencies and overrun behaviour.
module tb_ball_centroid_tracker;
  logic clk = 1'b0;
  logic rst, dv, vs, uf, en, oclr;
  logic [23:0] data;
  logic [10:0] bx;
  logic [9:0] by;
  logic [19:0] bp;
  logic bf, rv, ov;
  int checks = 0;
  int fails = 0;
  int lat, pulses;
  localparam logic [23:0] QUAL = 24'hC84020;
  localparam logic [23:0] BG = 24'h101010;
  always #5 clk = ~clk;
  ball_centroid_tracker dut (
    .clk_clk(clk), .reset_reset(rst), .vid_data(data), .vid_datavalid(dv),
    .vid_v_sync(vs), .vid_underflow(uf), .enable(en), .overrun_clr(oclr),
    .ball_x(bx), .ball_y(by), .ball_pixels(bp), .ball_found(bf),
    .result_valid(rv), .overrun(ov)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // 16x16 frame, qualifying block [x0..x1]x[y0..y1], optional underflow pulse on line uf_line.
  task automatic send_frame(input int x0, input int x1, input int y0, input int y1, input int uf_line);
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        dv = 1'b1;
        data = (x >= x0 && x <= x1 && y >= y0 && y <= y1) ? QUAL : BG;
        uf = (y == uf_line && x == 0);
        tick();
      end
      dv = 1'b0;
      uf = 1'b0;
      data = BG;
      repeat (4) tick();
    end
  endtask
  // Frame edge at cycle 0, then watch `limit` cycles; l = first result_valid cycle, p = pulse count.
  task automatic run_e(input int limit, input int second_at, input int clr_at, input int rst_at,
                       input int en_off_at, output int l, output int p);
    vs = 1'b1;
    l = -1;
    p = 0;
    for (int n = 1; n <= limit; n++) begin
      tick();
      vs = (n == second_at);
      oclr = (n == clr_at);
      if (n == rst_at) rst = 1'b1;
      if (n == rst_at + 3) rst = 1'b0;
      if (n == en_off_at) en = 1'b0;
      if (n == en_off_at + 20) en = 1'b1;
      if (rv) begin
        p++;
        if (l < 0) l = n;
      end
    end
    vs = 1'b0;
    oclr = 1'b0;
    en = 1'b1;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; dv = 1'b0; vs = 1'b0; uf = 1'b0; en = 1'b1; oclr = 1'b0; data = BG;
    repeat (3) tick();
    checks++; if (bx !== 11'd0) begin fails++; $display("FAIL reset_x: got %0d want 0", bx); end
    checks++; if (by !== 10'd0) begin fails++; $display("FAIL reset_y: got %0d want 0", by); end
    checks++; if (bp !== 20'd0) begin fails++; $display("FAIL reset_pix: got %0d want 0", bp); end
    checks++; if (bf !== 1'b0) begin fails++; $display("FAIL reset_found: got %b want 0", bf); end
    checks++; if (rv !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rv); end
    checks++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", ov); end
    rst = 1'b0;
    tick();
    run_e(20, 0, 0, 0, 0, lat, pulses);
    checks++; if (pulses !== 0) begin fails++; $display("FAIL first_frame_drop: got %0d pulses want 0", pulses); end
  endtask
  task automatic test_found;
    send_frame(4, 13, 2, 11, -1);
    run_e(100, 0, 0, 0, 40, lat, pulses);
    checks++; if (lat !== 67) begin fails++; $display("FAIL found_latency: got %0d want 67", lat); end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL found_pulses: got %0d want 1", pulses); end
    checks++; if (bx !== 11'd8) begin fails++; $display("FAIL found_x: got %0d want 8", bx); end
    checks++; if (by !== 10'd6) begin fails++; $display("FAIL found_y: got %0d want 6", by); end
    checks++; if (bp !== 20'd100) begin fails++; $display("FAIL found_pix: got %0d want 100", bp); end
    checks++; if (bf !== 1'b1) begin fails++; $display("FAIL found_flag: got %b want 1", bf); end
  endtask
  task automatic test_small;
    send_frame(0, 7, 0, 0, -1);
    run_e(20, 0, 0, 0, 0, lat, pulses);
    checks++; if (lat !== 1) begin fails++; $display("FAIL small_latency: got %0d want 1", lat); end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL small_pulses: got %0d want 1", pulses); end
    checks++; if (bp !== 20'd8) begin fails++; $display("FAIL small_pix: got %0d want 8", bp); end
    checks++; if (bf !== 1'b0) begin fails++; $display("FAIL small_flag: got %b want 0", bf); end
    checks++; if (bx !== 11'd8) begin fails++; $display("FAIL small_x_hold: got %0d want 8", bx); end
    checks++; if (by !== 10'd6) begin fails++; $display("FAIL small_y_hold: got %0d want 6", by); end
  endtask
  task automatic test_underflow;
    send_frame(4, 13, 2, 11, 5);
    run_e(80, 0, 0, 0, 0, lat, pulses);
    checks++; if (pulses !== 0) begin fails++; $display("FAIL uf_drop: got %0d pulses want 0", pulses); end
    checks++; if (bp !== 20'd8) begin fails++; $display("FAIL uf_pix_hold: got %0d want 8", bp); end
    send_frame(2, 5, 0, 15, -1);
    run_e(100, 0, 0, 0, 0, lat, pulses);
    checks++; if (lat !== 67) begin fails++; $display("FAIL minpix_latency: got %0d want 67", lat); end
    checks++; if (bx !== 11'd3) begin fails++; $display("FAIL minpix_x: got %0d want 3", bx); end
    checks++; if (by !== 10'd7) begin fails++; $display("FAIL minpix_y: got %0d want 7", by); end
    checks++; if (bp !== 20'd64) begin fails++; $display("FAIL minpix_pix: got %0d want 64", bp); end
    checks++; if (bf !== 1'b1) begin fails++; $display("FAIL minpix_flag: got %b want 1", bf); end
  endtask
  task automatic test_overrun;
    send_frame(4, 13, 2, 11, -1);
    run_e(100, 10, 10, 0, 0, lat, pulses);
    checks++; if (lat !== 67) begin fails++; $display("FAIL ovr_latency: got %0d want 67", lat); end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL ovr_pulses: got %0d want 1", pulses); end
    checks++; if (bx !== 11'd8) begin fails++; $display("FAIL ovr_x: got %0d want 8", bx); end
    checks++; if (ov !== 1'b1) begin fails++; $display("FAIL ovr_set_wins: got %b want 1", ov); end
    oclr = 1'b1;
    tick();
    oclr = 1'b0;
    checks++; if (ov !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", ov); end
  endtask
  task automatic test_reset_mid_div;
    send_frame(4, 13, 2, 11, -1);
    run_e(100, 0, 0, 50, 0, lat, pulses);
    checks++; if (pulses !== 0) begin fails++; $display("FAIL middiv_pulses: got %0d want 0", pulses); end
    checks++; if (bx !== 11'd0) begin fails++; $display("FAIL middiv_x: got %0d want 0", bx); end
    checks++; if (by !== 10'd0) begin fails++; $display("FAIL middiv_y: got %0d want 0", by); end
    checks++; if (bp !== 20'd0) begin fails++; $display("FAIL middiv_pix: got %0d want 0", bp); end
    send_frame(4, 13, 2, 11, -1);
    run_e(80, 0, 0, 0, 0, lat, pulses);
    checks++; if (pulses !== 0) begin fails++; $display("FAIL middiv_first_drop: got %0d want 0", pulses); end
    send_frame(4, 13, 2, 11, -1);
    run_e(100, 0, 0, 0, 0, lat, pulses);
    checks++; if (lat !== 67) begin fails++; $display("FAIL recover_latency: got %0d want 67", lat); end
    checks++; if (bx !== 11'd8) begin fails++; $display("FAIL recover_x: got %0d want 8", bx); end
  endtask
  initial begin
    rst = 1'b1;
    test_reset();
    test_found();
    test_small();
    test_underflow();
    test_overrun();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
